// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor slice.
//   DEFAULT_WIDTH : default operand width used by the interface and the top.
//   state_t       : controller state encoding (S_IDLE = 0, S_RUN = 1).
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
// Groups the operand/handshake/result signals of the serial adder.
//   start, sub, a, b, cin : request side, driven by the master.
//   busy, done            : status, driven by the slave (the adder).
//   sum, cout, ovf        : result, driven by the slave, held between completions.
interface serial_adder_if import serial_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
// Purely combinational 1-bit full adder.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder/subtractor: one full-adder cell plus a registered carry,
// processing WIDTH-bit operands LSB-first at one bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/sub/a/b/cin in; busy/done/sum/cout/ovf out)
// A start seen while idle captures the operands; WIDTH clocks later done pulses
// for one cycle and sum/cout/ovf take the new result.
module serial_adder import serial_adder_pkg::*; #(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s;
  logic             co;
  logic             c_msb_in;
  logic             last;

  fa_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  // The new sum bit enters at the MSB so that after WIDTH shifts the
  // result register holds the sum in natural bit order.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = s;
    end else begin : g_res_wn
      assign res_next = {s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == LAST);

  // On the last bit the carry register still holds the carry into the MSB,
  // which is exactly what the overflow check needs.
  assign c_msb_in = carry;

  // Controller, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? 1'b1 : bus.cin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= co;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            bus.sum  <= res_next;
            bus.cout <= co;
            bus.ovf  <= co ^ c_msb_in;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 16, plus an
// exhaustive check of fa_cell. Stimulus pushes expected results into a
// per-instance queue; monitors pop and compare on every done pulse.
module tb_serial_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst8 = 1'b0;
  logic rst1 = 1'b0;
  logic rst16 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb8[$];
  exp_t sb1[$];
  exp_t sb16[$];
  res_t last8 = '0;
  res_t last1 = '0;
  res_t last16 = '0;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst8),  .bus(if8.slave));
  serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst1),  .bus(if1.slave));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst16), .bus(if16.slave));

  logic fx, fy, fci, fs, fco;
  fa_cell u_fa_chk (.x(fx), .y(fy), .ci(fci), .s(fs), .co(fco));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic and sign rules for overflow.
  function automatic res_t model(int w, logic s, logic [63:0] a, logic [63:0] b, logic ci);
    res_t        r;
    logic [64:0] full;
    logic [63:0] mask;
    logic        sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    if (!s) begin
      full   = {1'b0, a} + {1'b0, b} + 65'(ci);
      r.sum  = full[63:0] & mask;
      r.cout = full[w];
    end else begin
      r.sum  = (a - b) & mask;
      r.cout = (a >= b);
    end
    sa = a[w-1];
    sb = b[w-1];
    sr = r.sum[w-1];
    r.ovf = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(string name, exp_t e, logic [63:0] sum, logic cout, logic ovf);
    check({name, " sum"}, sum, e.r.sum);
    check({name, " cout"}, 64'(cout), 64'(e.r.cout));
    check({name, " ovf"}, 64'(ovf), 64'(e.r.ovf));
    check({name, " latency"}, 64'(cyc), 64'(e.due));
  endtask

  function automatic logic doneOf(int w);
    case (w)
      8:       return if8.done;
      1:       return if1.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic busyOf(int w);
    case (w)
      8:       return if8.busy;
      1:       return if1.busy;
      default: return if16.busy;
    endcase
  endfunction

  // Drives one start cycle from a negedge and records the expected result.
  task automatic applyStimulus(int w, logic s, logic [63:0] a, logic [63:0] b, logic ci);
    exp_t e;
    logic [63:0] mask;
    mask  = (64'd1 << w) - 64'd1;
    e.r   = model(w, s, a & mask, b & mask, ci);
    e.due = cyc + 1 + w;
    case (w)
      8: begin
        if8.start = 1'b1; if8.sub = s; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = ci;
        sb8.push_back(e);
      end
      1: begin
        if1.start = 1'b1; if1.sub = s; if1.a = a[0]; if1.b = b[0]; if1.cin = ci;
        sb1.push_back(e);
      end
      default: begin
        if16.start = 1'b1; if16.sub = s; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = ci;
        sb16.push_back(e);
      end
    endcase
    @(negedge clk);
    if8.start = 1'b0;
    if1.start = 1'b0;
    if16.start = 1'b0;
  endtask

  // Returns at the negedge where done is high, counting busy cycles seen.
  task automatic waitDone(int w, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (!doneOf(w) && n < 200) begin
      if (busyOf(w)) busy_cnt++;
      n++;
      @(negedge clk);
    end
    if (!doneOf(w)) begin
      checks++;
      errors++;
      $display("[TB] FAIL w%0d done timeout: got no done expected done within 200 cycles", w);
    end
  endtask

  // Monitors: compare on done, otherwise require the held result to be stable.
  always @(negedge clk) begin
    if (rst8) begin
      if (if8.done) begin
        if (sb8.size() == 0) check("w8 unexpected done", 64'(if8.done), 64'd0);
        else begin
          exp_t e;
          e = sb8.pop_front();
          checkOutput("w8", e, 64'(if8.sum), if8.cout, if8.ovf);
          last8 = e.r;
        end
      end else begin
        check("w8 hold", {if8.sum, if8.cout, if8.ovf}, {last8.sum[7:0], last8.cout, last8.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (rst1 && if1.done) begin
      if (sb1.size() == 0) check("w1 unexpected done", 64'(if1.done), 64'd0);
      else begin
        exp_t e;
        e = sb1.pop_front();
        checkOutput("w1", e, 64'(if1.sum), if1.cout, if1.ovf);
        last1 = e.r;
      end
    end
  end

  always @(negedge clk) begin
    if (rst16) begin
      if (if16.done) begin
        if (sb16.size() == 0) check("w16 unexpected done", 64'(if16.done), 64'd0);
        else begin
          exp_t e;
          e = sb16.pop_front();
          checkOutput("w16", e, 64'(if16.sum), if16.cout, if16.ovf);
          last16 = e.r;
        end
      end else begin
        check("w16 hold", {if16.sum, if16.cout, if16.ovf}, {last16.sum[15:0], last16.cout, last16.ovf});
      end
    end
  end

  initial begin
    int bc;
    logic [2:0] v;
    {if8.start, if8.sub, if8.a, if8.b, if8.cin} = '0;
    {if1.start, if1.sub, if1.a, if1.b, if1.cin} = '0;
    {if16.start, if16.sub, if16.a, if16.b, if16.cin} = '0;

    // Exhaustive full-adder cell check.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {fx, fy, fci} = v;
      #1;
      check("fa_cell", 64'({fco, fs}), 64'(fx) + 64'(fy) + 64'(fci));
    end

    repeat (3) @(negedge clk);
    check("w8 reset state", 64'({if8.busy, if8.done, if8.sum, if8.cout, if8.ovf}), 64'd0);
    rst8 = 1'b1;
    rst1 = 1'b1;
    rst16 = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 cases, chained back-to-back on the done cycle.
    applyStimulus(8, 1'b0, 64'h35, 64'h4A, 1'b0);
    waitDone(8, bc);
    check("w8 busy cycles", 64'(bc), 64'd8);
    applyStimulus(8, 1'b0, 64'hFF, 64'h01, 1'b1);
    waitDone(8, bc);
    applyStimulus(8, 1'b0, 64'h7F, 64'h01, 1'b0);
    waitDone(8, bc);
    @(negedge clk);
    applyStimulus(8, 1'b1, 64'h10, 64'h20, 1'b0);
    waitDone(8, bc);
    applyStimulus(8, 1'b1, 64'h80, 64'h01, 1'b0);
    waitDone(8, bc);
    @(negedge clk);

    // A start during busy must be ignored.
    applyStimulus(8, 1'b0, 64'h12, 64'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if8.start = 1'b1; if8.sub = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    waitDone(8, bc);
    @(negedge clk);

    // Reset during bit 4 aborts the operation with no done pulse.
    applyStimulus(8, 1'b0, 64'hAA, 64'h55, 1'b1);
    repeat (3) @(negedge clk);
    rst8 = 1'b0;
    #1;
    check("w8 async reset", 64'({if8.busy, if8.done, if8.sum, if8.cout, if8.ovf}), 64'd0);
    sb8.delete();
    last8 = '0;
    @(negedge clk);
    rst8 = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(8, 1'b0, 64'h01, 64'h02, 1'b1);
    waitDone(8, bc);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8, 1'($urandom_range(1)), 64'($urandom), 64'($urandom), 1'($urandom_range(1)));
      waitDone(8, bc);
    end

    // WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      applyStimulus(1, 1'b0, 64'(v[2]), 64'(v[1]), v[0]);
      waitDone(1, bc);
      @(negedge clk);
    end

    // WIDTH=16 random sweep.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16, 1'($urandom_range(1)), 64'($urandom), 64'($urandom), 1'($urandom_range(1)));
      waitDone(16, bc);
    end

    repeat (20) @(negedge clk);
    check("w8 scoreboard drained", 64'(sb8.size()), 64'd0);
    check("w1 scoreboard drained", 64'(sb1.size()), 64'd0);
    check("w16 scoreboard drained", 64'(sb16.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor built around a single 1-bit full-adder cell and a registered carry.
- Accepts two WIDTH-bit operands on a start strobe, processes them LSB-first at one bit per clock, and reports sum, carry-out and signed overflow with a done pulse.
- Successor to the combinational full adder. It trades latency for area and adds subtract mode, overflow detection and a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  load operands and begin operation; sampled only when not busy.
- sub  input  1  0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored).
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in for add mode, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start completes.
- cout  output  1  carry out of MSB (subtract: 1 = no borrow).
- ovf  output  1  signed overflow, computed as carry-into-MSB XOR carry-out-of-MSB.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, carry register and counter all 0. Reset mid-operation aborts the operation; no done pulse is issued.
- States are IDLE and RUN. There is no separate DONE state; done is a registered pulse.
- IDLE: on a rising edge with start=1, capture a into shift register A and b (or ~b if sub) into shift register B. Load the carry register with cin (or 1 if sub). Clear the counter, go to RUN, and assert busy.
- RUN, on each edge:
  - FA cell computes s,c from A[0], B[0] and the carry register.
  - s shifts into the result register at MSB; the result register shifts right.
  - A and B shift right; the carry register takes c; the counter increments.
  - On the edge where the counter reaches WIDTH-1 (the last bit), the carry register value before update is saved as c_msb_in.
- Completion, on the edge processing bit WIDTH-1:
  - sum <= final result register value and cout <= c.
  - ovf <= c XOR c_msb_in.
  - done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E(WIDTH). That is WIDTH clocks, one bit per clock.
- start while busy=1 is ignored; operands are not re-captured.
- start in the cycle done is high is accepted (back-to-back). sum/cout/ovf keep the previous result until the new operation completes.
- sum/cout/ovf update only at completion; intermediate bits are never visible on sum.
- WIDTH=1: single RUN cycle; c_msb_in equals the initial carry.
- a, b, sub and cin are don't-care outside the start-accept cycle.

Decomposition:
- Shared package serial_adder_pkg holds the state encoding localparams (S_IDLE=1'b0, S_RUN=1'b1).
- One natural sub-module: fa_cell, a purely combinational 1-bit full adder (x, y, ci -> s, co). It is instantiated once, and the bench also checks it exhaustively.
- Counter, shift registers and FSM stay in serial_adder.

Test Plan:
- WIDTH=8, add, a=8'h35, b=8'h4A, cin=0 -> after 8 clks done=1 for 1 cycle, sum=8'h7F, cout=0, ovf=0; busy high exactly 8 cycles.
- WIDTH=8, add, a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- WIDTH=8, sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, cout=0 (borrow), ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Second start pulsed at cycle 3 of a busy operation -> ignored, first result unchanged. start asserted during the done cycle -> accepted, next done exactly 8 clks later.
- rst_n driven low at bit 4 of an operation -> busy, done, sum, cout and ovf go to 0 immediately. No done pulse follows, and the next start completes normally.
- WIDTH=1, all 8 combinations of a, b and cin in add mode -> {cout,sum} matches the full-adder truth table, with done 1 clk after each start. Random 1000-vector sweep at WIDTH=16 checked against a+b+cin and a-b reference.
